div_share_sched: RTL and testbench

Sequential scheduler that runs the z = (a % b == zero) ? a/b : c/d function on one shared, iterative unsigned divide/modulus unit instead of parallel DIV/MOD instances. The block is a small HLSM with a Start/Done handshake, intended as the area-reduced alternative to the fully combinational datapath. The divider is internal: a restoring, one-quotient-bit-per-cycle shift/subtract loop. It is shared over time between the (a,b) and (c,d) division requests.

---
 rtl/div_share_sched.sv | 135 +++++++++++++
 tb/tb_div_share_sched.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_share_sched.sv
// div_share_sched: computes z = (a % b == zero) ? a/b : c/d on one shared
// restoring divider that produces one quotient bit per cycle.
// Optional macro DIV_SHARE_SCHED_DIVZERO_FLAG_EN adds the DivZero output,
// which reports a zero divisor for the quotient placed on z.
module div_share_sched #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] zero,
    output logic [DATAWIDTH-1:0] z,
    output logic                 Done,
`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
    output logic                 DivZero,
`endif
    output logic                 Busy
);

    localparam int CW = $clog2(DATAWIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    typedef enum logic [2:0] {IDLE, DIV_AB, CHECK, DIV_CD, FINISH} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] c_r, d_r, zero_r;
    logic [DATAWIDTH-1:0] dvs;          // current divisor
    logic [DATAWIDTH-1:0] quo;          // dividend bits shift out, quotient bits shift in
    logic [DATAWIDTH:0]   rem;          // one extra bit so the trial compare cannot overflow
    logic [DATAWIDTH:0]   trial, rem_step;
    logic [DATAWIDTH-1:0] quo_step;
    logic                 fits, last, rem_eq;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // A zero divisor always fits, which yields an all-ones quotient and rem = dividend.
    always_comb begin
        trial    = {rem[DATAWIDTH-1:0], quo[DATAWIDTH-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_step = fits ? (trial - {1'b0, dvs}) : trial;
        quo_step = {quo[DATAWIDTH-2:0], fits};
        last     = (cnt == LAST);
        rem_eq   = (rem == {1'b0, zero_r});
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs decoded from the state.
    always_comb begin
        state_nxt = state;
        Done      = 1'b0;
        Busy      = 1'b1;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) state_nxt = DIV_AB;
            end
            DIV_AB:  if (last) state_nxt = CHECK;
            CHECK:   state_nxt = rem_eq ? FINISH : DIV_CD;
            DIV_CD:  if (last) state_nxt = FINISH;
            FINISH: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
    // Zero-divisor flag, updated together with z.
    always_ff @(posedge Clk) begin
        if (Rst)
            DivZero <= 1'b0;
        else if ((state == CHECK && rem_eq) || (state == DIV_CD && last))
            DivZero <= (dvs == '0);
    end
`endif

    // Operand capture, shared divider iteration and result register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            z      <= '0;
            cnt    <= '0;
            c_r    <= '0;
            d_r    <= '0;
            zero_r <= '0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    c_r    <= c;
                    d_r    <= d;
                    zero_r <= zero;
                    dvs    <= b;
                    quo    <= a;
                    rem    <= '0;
                    cnt    <= '0;
                end
                DIV_AB: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CW'(1);
                end
                CHECK: begin
                    if (rem_eq) begin
                        z <= quo;
                    end else begin
                        dvs <= d_r;
                        quo <= c_r;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                DIV_CD: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CW'(1);
                    if (last) z <= quo_step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed and random operations checked against an
// arithmetic reference of z = (a % b == zero) ? a/b : c/d with its latency.
module tb_div_share_sched;

    localparam int W = 64;

    logic         Clk = 1'b0;
    logic         Rst, Start;
    logic [W-1:0] a, b, c, d, zero, z;
    logic         Done, Busy;
    logic         dz_obs;
`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
    logic         DivZero;
`endif

    int vectors    = 0;
    int miscompares = 0;

    div_share_sched #(.DATAWIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start),
        .a(a), .b(b), .c(c), .d(d), .zero(zero),
        .z(z), .Done(Done),
`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
        .DivZero(DivZero),
`endif
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference divider: division by zero gives all ones / the dividend.
    function automatic logic [W-1:0] qdiv(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? {W{1'b1}} : x / y;
    endfunction
    function automatic logic [W-1:0] rmod(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? x : x % y;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation in the current cycle (cycle 0) and follow it through
    // the IDLE cycle after Done. hold keeps Start high; chg scrambles operands at cycle 5.
    task automatic run_op(input logic [W-1:0] ia, ib, ic, id, iz, input bit hold, input bit chg);
        bit           eq;
        int           lat, done_at, done_cnt;
        bit           busy_ok;
        logic [W-1:0] ez, z_done;
        logic         edz, dz_done;
        eq  = (rmod(ia, ib) == iz);
        lat = eq ? W + 2 : 2 * W + 2;
        ez  = eq ? qdiv(ia, ib) : qdiv(ic, id);
        edz = eq ? (ib == 0) : (id == 0);
        a = ia; b = ib; c = ic; d = id; zero = iz; Start = 1'b1;
        done_at = -1; done_cnt = 0; busy_ok = 1'b1; z_done = 'x; dz_done = 1'bx;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge Clk);
            if (!hold) Start = 1'b0;
            if (chg && n == 5) begin
                a = rnd64(); b = rnd64(); c = rnd64(); d = rnd64(); zero = rnd64();
            end
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n; z_done = z; dz_done = dz_obs;
                end
            end
            if (n <= lat && Busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("done_cycle", W'(done_at), W'(lat));
        chk("done_count", W'(done_cnt), W'(1));
        chk("z_at_done", z_done, ez);
        chk("busy_during", W'(busy_ok), W'(1));
        chk("busy_after", W'(Busy), W'(0));
        chk("z_hold", z, ez);
`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
        chk("divzero", W'(dz_done), W'(edz));
`else
        if (edz) ;
`endif
    endtask

`ifdef DIV_SHARE_SCHED_DIVZERO_FLAG_EN
    assign dz_obs = DivZero;
`else
    assign dz_obs = 1'b0;
`endif

    initial begin
        logic [W-1:0] ra, rb, rc, rd, rz;
        Rst = 1'b1; Start = 1'b1;
        a = '0; b = '0; c = '0; d = '0; zero = '0;
        // Reset wins over Start.
        repeat (3) @(negedge Clk);
        chk("reset_z", z, '0);
        chk("reset_done", W'(Done), W'(0));
        chk("reset_busy", W'(Busy), W'(0));
        Rst = 1'b0; Start = 1'b0;
        @(negedge Clk);

        // Directed cases; each starts in the IDLE cycle after the previous Done.
        run_op(100, 10, 7, 2, 0, 1'b0, 1'b0);
        run_op(101, 10, 7, 2, 0, 1'b0, 1'b0);
        run_op(101, 10, 7, 2, 1, 1'b0, 1'b0);
        run_op(5, 0, 9, 3, 5, 1'b0, 1'b0);
        run_op(5, 0, 9, 3, 0, 1'b0, 1'b0);
        run_op(9, 2, 5, 0, 3, 1'b0, 1'b0);

        // Start held high with operands scrambled mid-run; the IDLE cycle accepts again.
        run_op(101, 10, 7, 2, 0, 1'b1, 1'b1);
        @(negedge Clk);
        chk("restart_busy", W'(Busy), W'(1));
        Rst = 1'b1; Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        run_op(100, 10, 7, 2, 0, 1'b1, 1'b1);
        Start = 1'b0;
        @(negedge Clk);

        // Reset in the middle of DIV_AB, then restart at cycle 42.
        a = 101; b = 10; c = 7; d = 2; zero = 0; Start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("midrst_z", z, '0);
        chk("midrst_done", W'(Done), W'(0));
        chk("midrst_busy", W'(Busy), W'(0));
        @(negedge Clk);
        run_op(100, 10, 7, 2, 0, 1'b0, 1'b0);

        // Random operations over a mix of operand shapes.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = rnd64(); rb = rnd64() >> $urandom_range(0, 60); rc = rnd64(); rd = rnd64() >> $urandom_range(0, 60); rz = rnd64(); end
                1: begin ra = W'($urandom_range(0, 40)); rb = W'($urandom_range(0, 6)); rc = W'($urandom_range(0, 40)); rd = W'($urandom_range(0, 6)); rz = W'($urandom_range(0, 2)); end
                2: begin ra = rnd64(); rb = '0; rc = rnd64(); rd = W'($urandom_range(0, 3)); rz = rnd64(); end
                default: begin ra = rnd64(); rb = rnd64() >> $urandom_range(0, 63); rc = rnd64(); rd = rnd64(); rz = rmod(ra, rb); end
            endcase
            run_op(ra, rb, rc, rd, rz, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
